// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;

    // Debug-halt control FSM states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fsm_state_e;

    // Pipeline register stage indices
    localparam int PC     = 0;
    localparam int IF_ID  = 1;
    localparam int ID_EX  = 2;
    localparam int EX_MEM = 3;
    localparam int MEM_WB = 4;

    // Contiguous bit mask with bits lo..hi set (inclusive)
    function automatic logic [31:0] span_mask(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/debug request inputs and stall/flush control outputs of the pipeline controller.
interface pipe_ctrl_if #(
    parameter int STAGES = 5
);
    logic              lu_hazard_i;
    logic              jump_i;
    logic              ex_busy_i;
    logic              halt_req_i;
    logic              resume_req_i;
    logic              reset_req_i;
    logic [STAGES-1:0] stall_o;
    logic [STAGES-1:0] flush_o;
    logic              halted_o;
    logic              soft_rst_o;

    // Core / debug side: raises requests, consumes pipeline controls
    modport master (
        output lu_hazard_i, jump_i, ex_busy_i, halt_req_i, resume_req_i, reset_req_i,
        input  stall_o, flush_o, halted_o, soft_rst_o
    );

    // Controller side
    modport slave (
        input  lu_hazard_i, jump_i, ex_busy_i, halt_req_i, resume_req_i, reset_req_i,
        output stall_o, flush_o, halted_o, soft_rst_o
    );
endinterface

// File: rtl/pipe_ctrl_halt_fsm.sv
// Debug halt FSM: run/drain/halted sequencing, drain counter and soft-reset pulse.
module halt_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = 5
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_jump,
    input  logic       i_ex_busy,
    input  logic       i_halt_req,
    input  logic       i_resume_req,
    input  logic       i_reset_req,
    output fsm_state_e o_state,
    output logic       o_halted,
    output logic       o_soft_rst
);
    localparam int CW = $clog2(STAGES);

    fsm_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_halted;
    logic          r_rst_seen;
    logic          r_soft_rst;

    // State, drain count, halted flag and the one-shot soft reset on a reset_req rising edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_halted   <= 1'b0;
            r_rst_seen <= 1'b0;
            r_soft_rst <= 1'b0;
        end else begin
            r_rst_seen <= i_reset_req;
            r_soft_rst <= i_reset_req & ~r_rst_seen;
            if (i_reset_req) begin
                r_state  <= ST_RUN;
                r_cnt    <= '0;
                r_halted <= 1'b0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (i_halt_req) begin
                            r_state <= ST_DRAIN;
                            r_cnt   <= CW'(STAGES - 1);
                        end
                    end
                    ST_DRAIN: begin
                        // A late jump refills the pipe, so the drain starts over
                        if (i_jump) begin
                            r_cnt <= CW'(STAGES - 1);
                        end else if (!i_ex_busy) begin
                            if (r_cnt <= CW'(1)) begin
                                r_state  <= ST_HALTED;
                                r_cnt    <= '0;
                                r_halted <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt - 1'b1;
                            end
                        end
                    end
                    ST_HALTED: begin
                        if (i_resume_req && !i_halt_req) begin
                            r_state  <= ST_RUN;
                            r_halted <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_state    = r_state;
    assign o_halted   = r_halted;
    assign o_soft_rst = r_soft_rst;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority mux over soft reset, jump, busy, load-use and halt.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES     = 5,
    parameter int JUMP_STAGE = 3,
    parameter int LU_STAGE   = 2
) (
    input  logic         clk,
    input  logic         rstn,
    pipe_ctrl_if.slave   bus
);
    fsm_state_e        w_state;
    logic              w_halted;
    logic              w_soft_rst;
    logic [STAGES-1:0] w_stall;
    logic [STAGES-1:0] w_flush;

    halt_fsm #(.STAGES(STAGES)) u_halt_fsm (
        .clk          (clk),
        .rstn         (rstn),
        .i_jump       (bus.jump_i),
        .i_ex_busy    (bus.ex_busy_i),
        .i_halt_req   (bus.halt_req_i),
        .i_resume_req (bus.resume_req_i),
        .i_reset_req  (bus.reset_req_i),
        .o_state      (w_state),
        .o_halted     (w_halted),
        .o_soft_rst   (w_soft_rst)
    );

    // Highest-priority event wins; load-use responds in the same cycle it is raised
    always_comb begin
        w_stall = '0;
        w_flush = '0;
        if (w_soft_rst) begin
            w_flush = '1;
        end else if (bus.jump_i) begin
            w_flush = STAGES'(span_mask(IF_ID, JUMP_STAGE));
        end else if (bus.ex_busy_i) begin
            w_stall = STAGES'(span_mask(PC, JUMP_STAGE - 1));
            w_flush = STAGES'(span_mask(JUMP_STAGE, JUMP_STAGE));
        end else if (bus.lu_hazard_i) begin
            w_stall = STAGES'(span_mask(PC, LU_STAGE - 1));
            w_flush = STAGES'(span_mask(LU_STAGE, LU_STAGE));
        end else if (w_state != ST_RUN) begin
            // Freeze fetch and feed bubbles so the downstream stages empty out
            w_stall = STAGES'(span_mask(PC, PC));
            w_flush = STAGES'(span_mask(IF_ID, IF_ID));
        end
    end

    assign bus.stall_o    = w_stall;
    assign bus.flush_o    = w_flush;
    assign bus.halted_o   = w_halted;
    assign bus.soft_rst_o = w_soft_rst;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STAGES, default 5: number of pipeline register stages; index 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB; legal range 4..8.
REQ-002 Parameter JUMP_STAGE, default 3: index of the stage whose output carries the resolved jump; legal range 2..STAGES-2.
REQ-003 Parameter LU_STAGE, default 2: index of the stage that receives the load-use bubble; legal range 1..JUMP_STAGE-1.
REQ-004 Port clk, input, 1: single core clock; all state updates on its rising edge.
REQ-005 Port rstn, input, 1: reset; asynchronous, active-low.
REQ-006 Port lu_hazard_i, input, 1: load-use hazard detected in ID.
REQ-007 Port jump_i, input, 1: taken jump/branch resolved at JUMP_STAGE.
REQ-008 Port ex_busy_i, input, 1: multi-cycle execute unit not done.
REQ-009 Port halt_req_i, input, 1: debug halt request (level).
REQ-010 Port resume_req_i, input, 1: debug resume request (level).
REQ-011 Port reset_req_i, input, 1: debug soft-reset request (level).
REQ-012 Port stall_o, output, STAGES: bit i high means stage i holds its contents.
REQ-013 Port flush_o, output, STAGES: bit i high means stage i loads a bubble (all control signals zero).
REQ-014 Port halted_o, output, 1: core is halted and the pipeline is empty.
REQ-015 Port soft_rst_o, output, 1: one-cycle pulse resetting PC and flushing every stage.

Function
REQ-016 Control FSM states: RUN, DRAIN, HALTED.
REQ-017 Transitions: RUN->DRAIN on halt_req_i; DRAIN->HALTED when the drain counter reaches 0; HALTED->RUN on resume_req_i with halt_req_i low; any state->RUN on reset_req_i.
REQ-018 Drain counter width is clog2(STAGES); loaded with STAGES-1 on RUN->DRAIN; decrements by 1 each DRAIN cycle with ex_busy_i low; holds while ex_busy_i is high; reloads to STAGES-1 on jump_i in DRAIN.
REQ-019 Output priority, highest first: soft reset, jump, ex_busy, load-use, halt.
REQ-020 Soft reset: soft_rst_o=1 for exactly the cycle after reset_req_i first samples high; flush_o all ones in that cycle; stall_o=0; a level held high produces only one pulse until it is deasserted.
REQ-021 Jump: flush_o[1..JUMP_STAGE]=1; stall_o[0]=0, so PC takes the redirect; a simultaneous lu_hazard_i or ex_busy_i is ignored.
REQ-022 ex_busy_i without jump_i: stall_o[0..JUMP_STAGE-1]=1; flush_o[JUMP_STAGE]=1; stages above JUMP_STAGE continue.
REQ-023 lu_hazard_i alone: stall_o[0..LU_STAGE-1]=1; flush_o[LU_STAGE]=1; latency 0 (combinational from inputs and state).
REQ-024 DRAIN and HALTED, with no higher-priority event: stall_o[0]=1 and flush_o[1]=1; downstream stages advance bubbles.
REQ-025 halted_o=1 only in HALTED; it deasserts in the same cycle the FSM leaves HALTED.
REQ-026 halt_req_i and resume_req_i both high in HALTED: remain HALTED.
REQ-027 halt_req_i deasserted during DRAIN: drain still completes into HALTED (no abort).

Reset
REQ-028 rstn low: FSM=RUN, drain counter=0, soft-reset edge flag=0, soft_rst_o=0, halted_o=0; stall_o and flush_o=0 when all request inputs are low.
REQ-029 rstn released mid-DRAIN or in HALTED: the next cycle starts in RUN with no residual stall.

Structure
REQ-030 FSM state encodings and stage index constants (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) shall live in the shared defines file.
REQ-031 One sub-module, halt_fsm: it contains the FSM, the drain counter and the soft-reset edge detect; the top-level module contains only the combinational stall/flush priority mux.

Verification
REQ-032 lu_hazard_i=1 for 1 cycle, defaults -> stall_o=5'b00011, flush_o=5'b00100 in that cycle; all zero the next cycle.
REQ-033 jump_i=1 together with lu_hazard_i=1 and ex_busy_i=1 -> stall_o=5'b00000, flush_o=5'b01110.
REQ-034 halt_req_i pulse, no other activity -> DRAIN for 4 cycles, halted_o=1 on the 5th cycle; stall_o[0]=1 and flush_o[1]=1 throughout; resume_req_i=1 -> halted_o=0 and stall_o=0 on the next cycle.
REQ-035 halt_req_i, then ex_busy_i=1 for 3 cycles mid-drain -> halted_o is delayed by exactly 3 cycles relative to REQ-034.
REQ-036 reset_req_i held high 4 cycles while HALTED -> exactly one soft_rst_o pulse with flush_o=5'b11111; FSM=RUN; halted_o=0.
REQ-037 rstn asserted asynchronously mid-DRAIN, between clock edges -> halted_o=0 and stall_o=0 immediately; RUN after release.
